// File: rtl/imem_loadable.sv
// Loadable instruction memory: streaming image load with an auto-incrementing
// write pointer, registered one-cycle fetch, and per-word valid bits so that
// words not written in the current image read back as zero.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | after reset, no image present; fetches are dropped
// S_LOAD  | image being streamed in, one word per cycle while load_en is high
// S_READY | image complete; fetches served, load_en starts a fresh image
module imem_loadable #(
    parameter int N          = 32,
    parameter int DEPTH      = 64,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  logic [N-1:0]  load_data,
    input  logic          fetch_req,
    input  logic [AW-1:0] addr,
    output logic [N-1:0]  q,
    output logic          q_valid,
    output logic          busy,
    output logic [AW:0]   load_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_READY
    } state_t;

    localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

    state_t           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [DEPTH-1:0] wvalid_q, wvalid_d;
    logic [N-1:0]     q_q, q_d;
    logic             q_valid_q, q_valid_d;
    // Set when an image fills the memory while load_en is still high; the rest
    // of that burst is discarded until load_en drops, so an over-long stream
    // cannot silently start a second image on top of the first.
    logic             drain_q, drain_d;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [N-1:0]     mem_q [DEPTH];

    logic             addr_in_range;
    logic [N-1:0]     rd_word;

    assign addr_in_range = ({1'b0, addr} < DEPTH_CNT);

    // Fetch data: only words written in the current image and inside the array.
    always_comb begin
        rd_word = '0;
        if (addr_in_range && wvalid_q[addr]) begin
            rd_word = mem_q[addr];
        end
    end

    // Next-state, load pointer, valid bits and fetch result.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        wvalid_d  = wvalid_q;
        q_d       = q_q;
        q_valid_d = 1'b0;
        drain_d   = drain_q && load_en;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;

        case (state_q)
            S_IDLE: begin
                if (load_en) begin
                    mem_we      = 1'b1;
                    mem_waddr   = '0;
                    wvalid_d[0] = 1'b1;
                    ptr_d       = AW'(1);
                    count_d     = (AW + 1)'(1);
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_en) begin
                    mem_we          = 1'b1;
                    mem_waddr       = ptr_q;
                    wvalid_d[ptr_q] = 1'b1;
                    ptr_d           = ptr_q + AW'(1);
                    count_d         = count_q + (AW + 1)'(1);
                    if (ptr_q == LAST_PTR) begin
                        state_d = S_READY;
                        drain_d = 1'b1;
                    end
                end else begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (load_en) begin
                    if (!drain_q) begin
                        mem_we      = 1'b1;
                        mem_waddr   = '0;
                        wvalid_d    = '0;
                        wvalid_d[0] = 1'b1;
                        ptr_d       = AW'(1);
                        count_d     = (AW + 1)'(1);
                        state_d     = S_LOAD;
                    end
                end else if (fetch_req) begin
                    q_d       = rd_word;
                    q_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers; valid bits cleared on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            count_q   <= '0;
            wvalid_q  <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            drain_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            count_q   <= count_d;
            wvalid_q  <= wvalid_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            drain_q   <= drain_d;
        end
    end

    // Storage array; contents survive reset, the valid bits gate visibility.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[mem_waddr] <= load_data;
        end
    end

    assign q          = q_q;
    assign q_valid    = q_valid_q;
    assign busy       = (state_q == S_LOAD);
    assign load_count = count_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: a default 64-word instance and an 8-word instance
// share clock and reset. Expected fetch results are queued when a fetch is
// accepted and compared when q_valid is observed.
module tb_imem_loadable;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        load_en, fetch_req;
    logic [31:0] load_data;
    logic [5:0]  addr;
    logic [31:0] q;
    logic        q_valid, busy;
    logic [6:0]  load_count;

    logic        e_load_en, e_fetch_req;
    logic [31:0] e_load_data;
    logic [2:0]  e_addr;
    logic [31:0] e_q;
    logic        e_q_valid, e_busy;
    logic [3:0]  e_load_count;

    imem_loadable dut64 (
        .clk        (clk),
        .reset      (reset),
        .load_en    (load_en),
        .load_data  (load_data),
        .fetch_req  (fetch_req),
        .addr       (addr),
        .q          (q),
        .q_valid    (q_valid),
        .busy       (busy),
        .load_count (load_count)
    );

    imem_loadable #(.N(32), .DEPTH(8)) dut8 (
        .clk        (clk),
        .reset      (reset),
        .load_en    (e_load_en),
        .load_data  (e_load_data),
        .fetch_req  (e_fetch_req),
        .addr       (e_addr),
        .q          (e_q),
        .q_valid    (e_q_valid),
        .busy       (e_busy),
        .load_count (e_load_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sb64[$];
    logic [31:0] sb8[$];
    logic [31:0] exp64, exp8;
    logic [31:0] prog[$];
    logic [31:0] img[$];
    logic [31:0] e_prog[10];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitors: q_valid must appear exactly when a result is owed.
    always @(negedge clk) begin
        if (!reset && (q_valid || sb64.size() != 0)) begin
            check_val("q_valid64", q_valid, sb64.size() != 0);
            if (sb64.size() != 0) begin
                exp64 = sb64.pop_front();
                if (q_valid) check_val("q64", q, exp64);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && (e_q_valid || sb8.size() != 0)) begin
            check_val("q_valid8", e_q_valid, sb8.size() != 0);
            if (sb8.size() != 0) begin
                exp8 = sb8.pop_front();
                if (e_q_valid) check_val("q8", e_q, exp8);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int sel, input int a, input logic acc, input logic [31:0] e);
        if (sel == 0) begin
            fetch_req = 1'b1;
            addr      = 6'(a);
        end else begin
            e_fetch_req = 1'b1;
            e_addr      = 3'(a);
        end
        @(posedge clk);
        if (acc) begin
            if (sel == 0) sb64.push_back(e);
            else          sb8.push_back(e);
        end
        #1;
        fetch_req   = 1'b0;
        e_fetch_req = 1'b0;
    endtask

    task automatic load_img64(input logic [31:0] w[$]);
        foreach (w[i]) begin
            load_en   = 1'b1;
            load_data = w[i];
            tick();
        end
        load_en = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        load_en = 1'b0; fetch_req = 1'b0; load_data = '0; addr = '0;
        e_load_en = 1'b0; e_fetch_req = 1'b0; e_load_data = '0; e_addr = '0;

        for (int i = 0; i < 47; i++)
            prog.push_back(32'h1357_0000 ^ (32'(i) << 8) ^ 32'(i));
        prog[0]  = 32'hf800_0001;
        prog[3]  = 32'h8b05_0083;
        prog[46] = 32'hb400_001f;
        for (int i = 0; i < 10; i++) e_prog[i] = 32'he000_0000 + 32'(i);

        repeat (3) tick();
        @(negedge clk);
        check_val("rst_q", q, 0);
        check_val("rst_q_valid", q_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_load_count", load_count, 0);
        check_val("rst_load_count8", e_load_count, 0);
        reset = 1'b0;
        tick();

        // Fetch with no image is dropped.
        fetch(0, 0, 1'b0, 32'h0);
        @(negedge clk);
        check_val("idle_q_valid", q_valid, 0);
        check_val("idle_q", q, 0);
        check_val("idle_busy", busy, 0);
        check_val("idle_load_count", load_count, 0);
        tick();

        // DEPTH=8: ten-word burst; the image completes at word 7.
        for (int i = 0; i < 10; i++) begin
            e_load_en   = 1'b1;
            e_load_data = e_prog[i];
            tick();
            if (i == 3) check_val("d8_busy_mid", e_busy, 1);
            if (i == 7) begin
                check_val("d8_count_full", e_load_count, 8);
                check_val("d8_busy_full", e_busy, 0);
            end
        end
        check_val("d8_count_after", e_load_count, 8);
        check_val("d8_busy_after", e_busy, 0);
        e_load_en = 1'b0;
        tick();
        fetch(1, 7, 1'b1, e_prog[7]);
        fetch(1, 0, 1'b1, e_prog[0]);
        tick();
        check_val("d8_count_final", e_load_count, 8);

        // 47-word program, then sequential fetch over the whole address space.
        for (int i = 0; i < 47; i++) begin
            load_en   = 1'b1;
            load_data = prog[i];
            tick();
            if (i == 10) check_val("load_busy", busy, 1);
        end
        load_en = 1'b0;
        tick();
        check_val("load_busy_done", busy, 0);
        check_val("load_count47", load_count, 47);
        for (int a = 0; a < 64; a++)
            fetch(0, a, 1'b1, (a < 47) ? prog[a] : 32'h0);
        fetch(0, 5, 1'b1, prog[5]);
        tick();
        tick();
        check_val("q_hold", q, {32'h0, prog[5]});
        check_val("q_valid_clear", q_valid, 0);

        // Reload with a two-word image; old data past word 1 becomes invisible.
        img = {32'hf800_8002, 32'hf800_0203};
        load_img64(img);
        check_val("reload_count", load_count, 2);
        fetch(0, 2, 1'b1, 32'h0);
        fetch(0, 1, 1'b1, 32'hf800_0203);
        fetch(0, 0, 1'b1, 32'hf800_8002);
        tick();

        // load_en and fetch_req together in READY: load wins.
        load_en   = 1'b1;
        load_data = 32'hcafe_0001;
        fetch_req = 1'b1;
        addr      = 6'd1;
        tick();
        load_en   = 1'b0;
        fetch_req = 1'b0;
        check_val("both_q_valid", q_valid, 0);
        check_val("both_busy", busy, 1);
        check_val("both_count", load_count, 1);
        tick();
        fetch(0, 0, 1'b1, 32'hcafe_0001);
        fetch(0, 1, 1'b1, 32'h0);
        tick();

        // Reset in the middle of a load.
        for (int i = 0; i < 5; i++) begin
            load_en   = 1'b1;
            load_data = 32'h5a5a_0000 + 32'(i);
            tick();
        end
        #2;
        reset = 1'b1;
        sb64.delete();
        #1;
        check_val("rst_load_count_mid", load_count, 0);
        check_val("rst_busy_mid", busy, 0);
        @(negedge clk);
        load_en = 1'b0;
        reset   = 1'b0;
        tick();
        img = {32'h0ddb_a110};
        load_img64(img);
        check_val("fresh_count", load_count, 1);
        fetch(0, 1, 1'b1, 32'h0);
        fetch(0, 0, 1'b1, 32'h0ddb_a110);
        tick();

        // Reset right after an accepted fetch suppresses the pending result.
        fetch_req = 1'b1;
        addr      = 6'd0;
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        reset     = 1'b1;
        sb64.delete();
        #1;
        check_val("rst_fetch_q_valid", q_valid, 0);
        check_val("rst_fetch_q", q, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) tick();

        check_val("sb_drain64", sb64.size(), 0);
        check_val("sb_drain8", sb8.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
Parametrised instruction memory, successor to the fixed 64x32 combinational-read ROM. Adds three things:
- Runtime loading over a streaming load port with an auto-incrementing write pointer.
- Registered (1-cycle) fetch with a request/valid handshake.
- Per-word valid tracking, so unloaded or out-of-range words read as zero.

It sits between the testbench/boot loader and the processor fetch stage.

Parameters:
N, 32, instruction word width in bits.
DEPTH, 64, number of words; any value >= 2.
AW, $clog2(DEPTH), address width; derived, not to be overridden.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
load_en  input  1  load strobe; one word written per cycle while high.
load_data  input  N  word to write at the current load pointer.
fetch_req  input  1  fetch request; sampled on rising edge.
addr  input  AW  word address for fetch, sampled with fetch_req.
q  output  N  fetched instruction; valid when q_valid=1.
q_valid  output  1  one-cycle pulse, one cycle after an accepted fetch_req.
busy  output  1  high in LOAD state.
load_count  output  AW+1  number of words written in the current image (0..DEPTH).

Behaviour:
Reset (asynchronous):
- state=IDLE, ptr=0, load_count=0, q=0, q_valid=0, busy=0.
- All per-word valid bits cleared; the memory array itself is not reset.

States:
- IDLE: after reset; no image. Fetches ignored (q_valid stays 0).
- IDLE -> LOAD: load_en=1 writes load_data to word 0, ptr<=1, load_count<=1, busy<=1.
- LOAD, load_en=1: write word ptr, set its valid bit, ptr++, load_count++.
- LOAD, load_en=0: go to READY; load_count holds.
- LOAD, write at ptr=DEPTH-1: completes the image (load_count=DEPTH) and forces READY. Further load_en in that transition cycle has no effect.
- READY, load_en=1: starts a new image. All valid bits cleared, word 0 written, ptr=1, load_count=1, state LOAD.
- READY, fetch_req=1 (and load_en=0): fetch accepted.

Fetch:
- Next edge: q <= mem[addr] if the valid bit for addr is set, else 0; q_valid <= 1.
- q_valid clears the following cycle unless another fetch is accepted. Back-to-back fetches give one result per cycle.
- q holds its last value while q_valid=0.

Boundary cases:
- fetch_req in IDLE or LOAD: dropped, no q_valid, no error signalled.
- load_en and fetch_req together in READY: load wins, fetch dropped.
- addr >= load_count (including addr >= DEPTH when DEPTH is not a power of 2): q=0, q_valid=1.
- Reset asserted mid-load or mid-fetch: immediate return to the reset state. A partial image is invalidated, and a pending q_valid never appears.
- No combinational path from any input to any output.

Test Plan:
- Load the 47-word program (word0=32'hf8000001, word3=32'h8b050083, word46=32'hb400001f), then fetch addr 0..63 sequentially. Required: q_valid one cycle after each request; q matches words 0..46; q=0 for addr 47..63; load_count=47.
- After reset, fetch_req with addr=0 -> q_valid stays 0, q=0, state IDLE.
- With DEPTH=8, load 10 words -> state READY after word 7, load_count=8, words 8-9 discarded. Fetch addr 7 returns the 8th word.
- Reload in READY with 2 words (32'hf8008002, 32'hf8000203). Required: load_count=2, fetch addr 2 returns 0 even though the old image had data there.
- Assert reset during LOAD after 5 words. Required: load_count=0, busy=0, and a fetch after a fresh 1-word load of addr 1 returns 0.
- Raise load_en and fetch_req together in READY -> no q_valid that cycle, new load started, busy=1.
